blackjack_engine: RTL and testbench

//  Parametrised single-table blackjack round controller: deals player/dealer hands from an on-chip

---
 rtl/blackjack_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_blackjack_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_engine.sv
// Single-table blackjack round controller: LFSR card source, player hit/stand loop,
// automatic dealer play, round resolution and a saturating score counter.
module blackjack_engine #(
    parameter int unsigned MAX_CARDS    = 6,
    parameter int unsigned SCORE_W      = 5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned DEALER_STAND = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   deal_i,
    input  logic                   hit_i,
    input  logic                   stand_i,
    input  logic                   inj_valid_i,
    input  logic [3:0]             inj_card_i,
    output logic [4*MAX_CARDS-1:0] player_cards_o,
    output logic [4*MAX_CARDS-1:0] dealer_cards_o,
    output logic [6:0]             player_sum_o,
    output logic [6:0]             dealer_sum_o,
    output logic                   hole_hidden_o,
    output logic [2:0]             result_o,
    output logic [SCORE_W-1:0]     score_o,
    output logic                   busy_o
);

    localparam int unsigned CntW = $clog2(MAX_CARDS + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_CARDS);
    localparam logic [6:0] StandSum = 7'(DEALER_STAND);
    localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};

    localparam logic [2:0] ResNone = 3'd0;
    localparam logic [2:0] ResLose = 3'd1;
    localparam logic [2:0] ResWin  = 3'd2;
    localparam logic [2:0] ResDraw = 3'd3;
    localparam logic [2:0] ResBj   = 3'd4;

    typedef enum logic [2:0] {
        StIdle, StDeal, StPlayer, StPDraw, StDealer, StResolve, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [4*MAX_CARDS-1:0] pcards_q, pcards_d, dcards_q, dcards_d;
    logic [CntW-1:0]        pcnt_q, pcnt_d, dcnt_q, dcnt_d;
    logic [1:0]             deal_cnt_q, deal_cnt_d;
    logic                   hidden_q, hidden_d;
    logic [2:0]             result_q, result_d;
    logic [SCORE_W-1:0]     score_q, score_d;

    logic                   draw_ok;
    logic [3:0]             draw_rank;
    logic [6:0]             psum_q, dsum_q;
    logic                   p_bj, d_bj;
    logic [2:0]             res;

    // Best total of a hand: aces count 1, one of them promoted to 11 when that stays <= 21.
    function automatic logic [6:0] hand_sum(input logic [4*MAX_CARDS-1:0] h);
        logic [6:0] raw;
        logic       ace;
        logic [3:0] r;
        raw = '0;
        ace = 1'b0;
        for (int k = 0; k < MAX_CARDS; k++) begin
            r = h[4*k +: 4];
            if (r >= 4'd10) raw = raw + 7'd10;
            else            raw = raw + {3'b000, r};
            if (r == 4'd1) ace = 1'b1;
        end
        if (ace && (raw + 7'd10 <= 7'd21)) raw = raw + 7'd10;
        return raw;
    endfunction

    assign draw_ok   = inj_valid_i || ((lfsr_q[3:0] != 4'd0) && (lfsr_q[3:0] <= 4'd13));
    assign draw_rank = inj_valid_i ? inj_card_i : lfsr_q[3:0];
    assign psum_q    = hand_sum(pcards_q);
    assign dsum_q    = hand_sum(dcards_q);
    assign p_bj      = (pcnt_q == CntW'(2)) && (psum_q == 7'd21);
    assign d_bj      = (dcnt_q == CntW'(2)) && (dsum_q == 7'd21);

    // Round outcome, evaluated on the settled hands while in RESOLVE.
    always_comb begin
        res = ResLose;
        if (psum_q > 7'd21)       res = ResLose;
        else if (p_bj)            res = d_bj ? ResDraw : ResBj;
        else if (d_bj)            res = ResLose;
        else if (dsum_q > 7'd21)  res = ResWin;
        else if (psum_q == dsum_q) res = ResDraw;
        else if (psum_q > dsum_q) res = ResWin;
        else                      res = ResLose;
    end

    // Next-state logic: FSM, card placement, LFSR step, result and score update.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        pcards_d   = pcards_q;
        dcards_d   = dcards_q;
        pcnt_d     = pcnt_q;
        dcnt_d     = dcnt_q;
        deal_cnt_d = deal_cnt_q;
        hidden_d   = hidden_q;
        result_d   = result_q;
        score_d    = score_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (deal_i) begin
                    state_d    = StDeal;
                    pcards_d   = '0;
                    dcards_d   = '0;
                    pcnt_d     = '0;
                    dcnt_d     = '0;
                    deal_cnt_d = '0;
                    hidden_d   = 1'b1;
                    result_d   = ResNone;
                end
            end
            StDeal: begin
                if (draw_ok) begin
                    // Alternate P0, D0, P1, D1.
                    if (deal_cnt_q[0]) begin
                        dcards_d[4*dcnt_q +: 4] = draw_rank;
                        dcnt_d = dcnt_q + 1'b1;
                    end else begin
                        pcards_d[4*pcnt_q +: 4] = draw_rank;
                        pcnt_d = pcnt_q + 1'b1;
                    end
                    deal_cnt_d = deal_cnt_q + 2'd1;
                    if (deal_cnt_q == 2'd3) begin
                        if (hand_sum(pcards_d) == 7'd21 || hand_sum(dcards_d) == 7'd21) begin
                            state_d  = StResolve;
                            hidden_d = 1'b0;
                        end else begin
                            state_d = StPlayer;
                        end
                    end
                end
            end
            StPlayer: begin
                if (stand_i) begin
                    state_d  = StDealer;
                    hidden_d = 1'b0;
                end else if (hit_i) begin
                    state_d = StPDraw;
                end
            end
            StPDraw: begin
                if (draw_ok) begin
                    pcards_d[4*pcnt_q +: 4] = draw_rank;
                    pcnt_d = pcnt_q + 1'b1;
                    if (hand_sum(pcards_d) > 7'd21) begin
                        state_d  = StResolve;
                        hidden_d = 1'b0;
                    end else if (pcnt_d == MaxCnt) begin
                        state_d  = StDealer;
                        hidden_d = 1'b0;
                    end else begin
                        state_d = StPlayer;
                    end
                end
            end
            StDealer: begin
                if (dsum_q < StandSum && dcnt_q < MaxCnt) begin
                    if (draw_ok) begin
                        dcards_d[4*dcnt_q +: 4] = draw_rank;
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end else begin
                    state_d = StResolve;
                end
            end
            StResolve: begin
                result_d = res;
                state_d  = StDone;
                unique case (res)
                    ResBj:   score_d = (score_q >= ScoreMax - 1'b1) ? ScoreMax : score_q + 2'd2;
                    ResWin:  score_d = (score_q == ScoreMax) ? ScoreMax : score_q + 1'b1;
                    ResLose: score_d = (score_q == '0) ? '0 : score_q - 1'b1;
                    default: score_d = score_q;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any round in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            pcards_q   <= '0;
            dcards_q   <= '0;
            pcnt_q     <= '0;
            dcnt_q     <= '0;
            deal_cnt_q <= '0;
            hidden_q   <= 1'b0;
            result_q   <= ResNone;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pcards_q   <= pcards_d;
            dcards_q   <= dcards_d;
            pcnt_q     <= pcnt_d;
            dcnt_q     <= dcnt_d;
            deal_cnt_q <= deal_cnt_d;
            hidden_q   <= hidden_d;
            result_q   <= result_d;
            score_q    <= score_d;
        end
    end

    // Display view: hole card and dealer total are concealed until revealed.
    always_comb begin
        dealer_cards_o = dcards_q;
        if (hidden_q) dealer_cards_o[7:4] = 4'h0;
        dealer_sum_o   = hidden_q ? 7'd0 : dsum_q;
    end

    assign player_cards_o = pcards_q;
    assign player_sum_o   = psum_q;
    assign hole_hidden_o  = hidden_q;
    assign result_o       = result_q;
    assign score_o        = score_q;
    assign busy_o         = (state_q == StDeal) || (state_q == StPDraw) ||
                            (state_q == StDealer) || (state_q == StResolve);

endmodule

// File: tb/tb_blackjack_engine.sv
// Directed self-checking bench for blackjack_engine using injected cards.
module tb_blackjack_engine;

    logic        clk = 1'b0;
    logic        rst, deal_i, hit_i, stand_i, inj_valid_i;
    logic [3:0]  inj_card_i;
    logic [23:0] player_cards_o, dealer_cards_o;
    logic [6:0]  player_sum_o, dealer_sum_o;
    logic        hole_hidden_o, busy_o;
    logic [2:0]  result_o;
    logic [4:0]  score_o;

    int checks = 0;
    int errors = 0;
    int exp_score;
    int waited;

    blackjack_engine dut (
        .clk            (clk),
        .rst            (rst),
        .deal_i         (deal_i),
        .hit_i          (hit_i),
        .stand_i        (stand_i),
        .inj_valid_i    (inj_valid_i),
        .inj_card_i     (inj_card_i),
        .player_cards_o (player_cards_o),
        .dealer_cards_o (dealer_cards_o),
        .player_sum_o   (player_sum_o),
        .dealer_sum_o   (dealer_sum_o),
        .hole_hidden_o  (hole_hidden_o),
        .result_o       (result_o),
        .score_o        (score_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Deal pulse then four injected cards in order P0, D0, P1, D1.
    task automatic do_deal(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
        deal_i = 1'b1;
        tick();
        deal_i = 1'b0;
        inj_valid_i = 1'b1;
        inj_card_i = c0; tick();
        inj_card_i = c1; tick();
        inj_card_i = c2; tick();
        inj_card_i = c3; tick();
        inj_valid_i = 1'b0;
    endtask

    task automatic stand_to_done();
        stand_i = 1'b1; tick(); stand_i = 1'b0;
        tick();  // DEALER sees total >= 17
        tick();  // RESOLVE
    endtask

    initial begin
        rst = 1'b1; deal_i = 1'b0; hit_i = 1'b0; stand_i = 1'b0;
        inj_valid_i = 1'b0; inj_card_i = 4'd0;
        tick(); tick();
        chk("rst_pcards", player_cards_o, 0);
        chk("rst_hidden", hole_hidden_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        exp_score = 0;

        // P 10,6 = 16 vs D 10,7 = 17; score floors at 0.
        do_deal(4'd10, 4'd10, 4'd6, 4'd7);
        chk("t2_psum", player_sum_o, 16);
        chk("t2_dsum_hidden", dealer_sum_o, 0);
        chk("t2_hidden", hole_hidden_o, 1);
        chk("t2_dcards_masked", dealer_cards_o, 24'h00000A);
        chk("t2_pcards", player_cards_o, 24'h00006A);
        chk("t2_busy_player", busy_o, 0);
        stand_i = 1'b1; tick(); stand_i = 1'b0;
        chk("t2_busy_dealer", busy_o, 1);
        chk("t2_dsum", dealer_sum_o, 17);
        tick(); tick();
        chk("t2_result", result_o, 1);
        chk("t2_score", score_o, exp_score);

        // Player natural: P 10,A vs D 9,7.
        do_deal(4'd10, 4'd9, 4'd1, 4'd7);
        chk("t1_busy_resolve", busy_o, 1);
        chk("t1_hidden", hole_hidden_o, 0);
        chk("t1_psum", player_sum_o, 21);
        chk("t1_dsum", dealer_sum_o, 16);
        tick();
        exp_score = 2;
        chk("t1_result", result_o, 4);
        chk("t1_score", score_o, exp_score);
        chk("t1_pcards", player_cards_o, 24'h00001A);
        chk("t1_dcards", dealer_cards_o, 24'h000079);

        // Both naturals push.
        do_deal(4'd10, 4'd10, 4'd1, 4'd1);
        tick();
        chk("bj_push_result", result_o, 3);
        chk("bj_push_score", score_o, exp_score);

        // Dealer natural beats player 19.
        do_deal(4'd10, 4'd1, 4'd9, 4'd13);
        tick();
        exp_score = 1;
        chk("d_bj_result", result_o, 1);
        chk("d_bj_score", score_o, exp_score);

        // Player busts with K; dealer draws nothing.
        do_deal(4'd10, 4'd5, 4'd6, 4'd6);
        hit_i = 1'b1; tick(); hit_i = 1'b0;
        chk("t3_busy_pdraw", busy_o, 1);
        inj_valid_i = 1'b1; inj_card_i = 4'd13; tick(); inj_valid_i = 1'b0;
        chk("t3_psum", player_sum_o, 26);
        tick();
        exp_score = 0;
        chk("t3_result", result_o, 1);
        chk("t3_score", score_o, exp_score);
        chk("t3_dslot2", dealer_cards_o[11:8], 0);

        // Dealer 16 draws 5 -> 21 beats P18.
        do_deal(4'd9, 4'd10, 4'd9, 4'd6);
        stand_i = 1'b1; tick(); stand_i = 1'b0;
        inj_valid_i = 1'b1; inj_card_i = 4'd5; tick(); inj_valid_i = 1'b0;
        tick(); tick();
        chk("t4a_dsum", dealer_sum_o, 21);
        chk("t4a_dcards", dealer_cards_o, 24'h00056A);
        chk("t4a_result", result_o, 1);
        chk("t4a_score", score_o, exp_score);

        // Same, dealer draws 10 -> bust.
        do_deal(4'd9, 4'd10, 4'd9, 4'd6);
        stand_i = 1'b1; tick(); stand_i = 1'b0;
        inj_valid_i = 1'b1; inj_card_i = 4'd10; tick(); inj_valid_i = 1'b0;
        tick(); tick();
        exp_score = 1;
        chk("t4b_dsum", dealer_sum_o, 26);
        chk("t4b_result", result_o, 2);
        chk("t4b_score", score_o, exp_score);

        // Player soft 17 (A,6) vs dealer hard 17 (9,8): push.
        do_deal(4'd1, 4'd9, 4'd6, 4'd8);
        chk("t5_psum_soft", player_sum_o, 17);
        stand_to_done();
        chk("t5_result", result_o, 3);
        chk("t5_score", score_o, exp_score);

        // Dealer soft 17 (A,6) stands without drawing; P18 wins.
        do_deal(4'd10, 4'd1, 4'd8, 4'd6);
        chk("s17_dsum_hidden", dealer_sum_o, 0);
        stand_to_done();
        exp_score = 2;
        chk("s17_dsum", dealer_sum_o, 17);
        chk("s17_dslot2", dealer_cards_o[11:8], 0);
        chk("s17_result", result_o, 2);
        chk("s17_score", score_o, exp_score);

        // hit/stand in DONE are ignored.
        hit_i = 1'b1; stand_i = 1'b1; tick(); hit_i = 1'b0; stand_i = 1'b0;
        chk("done_ignore_busy", busy_o, 0);
        chk("done_ignore_result", result_o, 2);

        // hit and stand together act as stand; dealer 11 draws 6 -> 17 beats P16.
        do_deal(4'd10, 4'd5, 4'd6, 4'd6);
        hit_i = 1'b1; stand_i = 1'b1; tick(); hit_i = 1'b0; stand_i = 1'b0;
        chk("hs_hidden", hole_hidden_o, 0);
        inj_valid_i = 1'b1; inj_card_i = 4'd6; tick(); inj_valid_i = 1'b0;
        tick(); tick();
        exp_score = 1;
        chk("hs_pslot2", player_cards_o[11:8], 0);
        chk("hs_result", result_o, 1);
        chk("hs_score", score_o, exp_score);

        // Reset while in P_DRAW aborts the round.
        do_deal(4'd10, 4'd5, 4'd6, 4'd6);
        hit_i = 1'b1; tick(); hit_i = 1'b0;
        rst = 1'b1; tick();
        chk("r6_pcards", player_cards_o, 0);
        chk("r6_dcards", dealer_cards_o, 0);
        chk("r6_psum", player_sum_o, 0);
        chk("r6_score", score_o, 0);
        chk("r6_busy", busy_o, 0);
        rst = 1'b0;
        hit_i = 1'b1; tick(); hit_i = 1'b0; tick();
        chk("r6_idle_hit_busy", busy_o, 0);
        chk("r6_idle_hit_pcards", player_cards_o, 0);

        // LFSR-sourced deal: every dealt rank must be legal.
        deal_i = 1'b1; tick(); deal_i = 1'b0;
        waited = 0;
        while (busy_o && waited < 200) begin
            tick();
            waited++;
        end
        chk("lfsr_deal_timeout", busy_o, 0);
        chk("lfsr_p0_ok", (player_cards_o[3:0] >= 1) && (player_cards_o[3:0] <= 13), 1);
        chk("lfsr_p1_ok", (player_cards_o[7:4] >= 1) && (player_cards_o[7:4] <= 13), 1);
        chk("lfsr_d0_ok", (dealer_cards_o[3:0] >= 1) && (dealer_cards_o[3:0] <= 13), 1);

        // Score saturation at 31 via repeated naturals.
        rst = 1'b1; tick(); rst = 1'b0;
        exp_score = 0;
        for (int i = 0; i < 17; i++) begin
            do_deal(4'd10, 4'd9, 4'd1, 4'd7);
            tick();
            exp_score = (exp_score + 2 > 31) ? 31 : exp_score + 2;
            chk($sformatf("sat_score_%0d", i), score_o, exp_score);
        end
        chk("sat_final", score_o, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
